// File: rtl/spi_slave.sv
// SPI mode-0 target (MSB first, 8-bit frames) behind the IPIF user-logic register port.
// SCK/MOSI/CSN are oversampled in Bus2IP_Clk; single-entry TX/RX buffers with overrun and irq.
//
// state  | meaning
// IDLE   | CSN high, miso driven low and not enabled
// ACTIVE | CSN low, shifting bytes; miso carries tx_shift[7]
module spi_slave #(
   parameter int C_NUM_REG    = 3,
   parameter int C_SLV_DWIDTH = 32
) (
   input  logic                        Bus2IP_Clk,
   input  logic                        Bus2IP_Resetn,
   input  logic [C_SLV_DWIDTH-1:0]     Bus2IP_Data,
   input  logic [C_SLV_DWIDTH/8-1:0]   Bus2IP_BE,
   input  logic [C_NUM_REG-1:0]        Bus2IP_RdCE,
   input  logic [C_NUM_REG-1:0]        Bus2IP_WrCE,
   output logic [C_SLV_DWIDTH-1:0]     IP2Bus_Data,
   output logic                        IP2Bus_RdAck,
   output logic                        IP2Bus_WrAck,
   output logic                        IP2Bus_Error,
   input  logic                        sck,
   input  logic                        mosi,
   input  logic                        csn,
   output logic                        miso,
   output logic                        miso_oe,
   output logic                        irq
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [2:0]  sck_q, csn_q;
   logic [1:0]  mosi_q;
   logic [7:0]  tx_buf_q, tx_buf_d, rx_buf_q, rx_buf_d;
   logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        tx_full_q, tx_full_d, rx_valid_q, rx_valid_d;
   logic        overrun_q, overrun_d, irq_en_q, irq_en_d;
   logic        miso_q, miso_d, miso_oe_q, miso_oe_d, irq_q, irq_d;
   logic        sck_rise, sck_fall, cs_fall, cs_rise;
   logic        wr_tx, wr_ctrl, rd_rx, byte_done;
   logic [7:0]  rx_next;
   logic        unused_bits;

   // stage [1] is the synchronized level, stage [2] is the delayed copy for edge detect
   assign sck_rise =  sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] &  sck_q[2];
   assign cs_fall  = ~csn_q[1] &  csn_q[2];
   assign cs_rise  =  csn_q[1] & ~csn_q[2];

   assign wr_tx   = Bus2IP_WrCE[2] & Bus2IP_BE[0];
   assign wr_ctrl = Bus2IP_WrCE[0] & Bus2IP_BE[0];
   assign rd_rx   = Bus2IP_RdCE[1];

   always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
      if (!Bus2IP_Resetn) begin
         sck_q      <= 3'b000;
         csn_q      <= 3'b111;
         mosi_q     <= 2'b00;
         state_q    <= IDLE;
         tx_buf_q   <= 8'h00;
         rx_buf_q   <= 8'h00;
         tx_shift_q <= 8'h00;
         rx_shift_q <= 8'h00;
         bit_cnt_q  <= 3'd0;
         tx_full_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         irq_en_q   <= 1'b0;
         miso_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         sck_q      <= {sck_q[1:0], sck};
         csn_q      <= {csn_q[1:0], csn};
         mosi_q     <= {mosi_q[0], mosi};
         state_q    <= state_d;
         tx_buf_q   <= tx_buf_d;
         rx_buf_q   <= rx_buf_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_full_q  <= tx_full_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         irq_en_q   <= irq_en_d;
         miso_q     <= miso_d;
         miso_oe_q  <= miso_oe_d;
         irq_q      <= irq_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tx_buf_d   = tx_buf_q;
      rx_buf_d   = rx_buf_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      tx_full_d  = tx_full_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q;
      irq_en_d   = irq_en_q;
      byte_done  = 1'b0;
      rx_next    = {rx_shift_q[6:0], mosi_q[1]};

      if (cs_rise) begin
         state_d   = IDLE;
         bit_cnt_d = 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_d    = ACTIVE;
                  tx_shift_d = tx_full_q ? tx_buf_q : 8'h00;
                  tx_full_d  = 1'b0;
                  bit_cnt_d  = 3'd0;
               end
            end
            ACTIVE: begin
               if (sck_rise) begin
                  rx_shift_d = rx_next;
                  if (bit_cnt_q == 3'd7) begin
                     byte_done  = 1'b1;
                     rx_buf_d   = rx_next;
                     tx_shift_d = tx_full_q ? tx_buf_q : 8'h00;
                     tx_full_d  = 1'b0;
                     bit_cnt_d  = 3'd0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end else if (sck_fall && bit_cnt_q != 3'd0) begin
                  // no shift on the fall before the first rise keeps a fresh MSB on the line
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (rd_rx)
         rx_valid_d = 1'b0;
      if (wr_ctrl) begin
         irq_en_d = Bus2IP_Data[0];
         if (Bus2IP_Data[1])
            overrun_d = 1'b0;
      end
      // a completing byte wins over both the read-clear and the overrun-clear
      if (byte_done) begin
         rx_valid_d = 1'b1;
         if (rx_valid_q && !rd_rx)
            overrun_d = 1'b1;
      end
      if (wr_tx) begin
         tx_buf_d  = Bus2IP_Data[7:0];
         tx_full_d = 1'b1;
      end

      miso_d    = (state_q == ACTIVE) & tx_shift_q[7];
      miso_oe_d = (state_q == ACTIVE);
      irq_d     = byte_done & irq_en_q;
   end

   always_comb begin
      IP2Bus_Data = '0;
      if (Bus2IP_RdCE[2])
         IP2Bus_Data = IP2Bus_Data | {{(C_SLV_DWIDTH-9){1'b0}}, tx_full_q, tx_buf_q};
      if (Bus2IP_RdCE[1])
         IP2Bus_Data = IP2Bus_Data | {{(C_SLV_DWIDTH-10){1'b0}}, overrun_q, rx_valid_q, rx_buf_q};
      if (Bus2IP_RdCE[0])
         IP2Bus_Data = IP2Bus_Data | {{(C_SLV_DWIDTH-1){1'b0}}, irq_en_q};
   end

   assign IP2Bus_RdAck = |Bus2IP_RdCE;
   assign IP2Bus_WrAck = |Bus2IP_WrCE;
   assign IP2Bus_Error = 1'b0;
   assign miso         = miso_q;
   assign miso_oe      = miso_oe_q;
   assign irq          = irq_q;

   assign unused_bits = ^{Bus2IP_Data[C_SLV_DWIDTH-1:8], Bus2IP_Data[7:2], Bus2IP_BE[C_SLV_DWIDTH/8-1:1]};

endmodule
